// File: rtl/find_my_best.sv
// find_my_best: picks the neighbour with the highest Q-value as next hop.
// Scans the neighbour Q-value table and the ID table in node memory. The
// chosen ID is written back to BEST_ADDR and also reported on the best_* ports.
//
// Ports:
//   clock, rst     - clock and synchronous active-high reset
//   en, start      - a start pulse is accepted only in idle while en is high
//   data_in        - memory read data for the address held this cycle
//   address        - registered memory byte address (16-bit words, stride 2)
//   data_out,wr_en - registered memory write data and write strobe
//   best_id/q/idx  - selected neighbour ID, its Q-value and its table index
//   none_found     - the last scan saw a clamped neighbour count of zero
//   busy, done     - busy is high outside idle; done is a one-cycle completion pulse
module find_my_best #(
  parameter int unsigned        ADDR_W       = 11,
  parameter int unsigned        WORD_W       = 16,
  parameter int unsigned        MAX_NBR      = 16,
  parameter logic [ADDR_W-1:0]  NBR_CNT_ADDR = 11'h274,
  parameter logic [ADDR_W-1:0]  NBR_ID_BASE  = 11'h072,
  parameter logic [ADDR_W-1:0]  QVAL_BASE    = 11'h052,
  parameter logic [ADDR_W-1:0]  BEST_ADDR    = 11'h276,
  parameter logic [WORD_W-1:0]  NONE_ID      = 16'hFFFF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  output logic [ADDR_W-1:0] address,
  output logic [WORD_W-1:0] data_out,
  output logic              wr_en,
  output logic [WORD_W-1:0] best_id,
  output logic [WORD_W-1:0] best_q,
  output logic [4:0]        best_idx,
  output logic              none_found,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CNT,
    S_RD_Q,
    S_RD_ID,
    S_WR_BEST,
    S_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   i;
  logic [IDX_W-1:0]   cnt;
  logic [WORD_W-1:0]  q;
  logic [WORD_W-1:0]  cur_best_q;
  logic [WORD_W-1:0]  cur_best_id;
  logic [IDX_W-1:0]   cur_best_idx;
  logic               have_best;

  logic [IDX_W-1:0]   i_nxt_c;
  logic [IDX_W-1:0]   cnt_clamped_c;
  logic               take_cand_c;

  // Next index, clamped neighbour count and candidate acceptance
  always_comb begin
    i_nxt_c       = i + IDX_W'(1);
    cnt_clamped_c = (data_in > WORD_W'(MAX_NBR)) ? IDX_W'(MAX_NBR) : IDX_W'(data_in);
    // Strict greater-than keeps the lower index on equal Q-values
    take_cand_c   = !have_best || (q > cur_best_q);
  end

  // Scan controller with registered outputs
  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= S_IDLE;
      address      <= '0;
      data_out     <= '0;
      wr_en        <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      best_id      <= NONE_ID;
      best_q       <= '0;
      best_idx     <= '0;
      none_found   <= 1'b0;
      i            <= '0;
      cnt          <= '0;
      q            <= '0;
      cur_best_q   <= '0;
      cur_best_id  <= NONE_ID;
      cur_best_idx <= '0;
      have_best    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && start) begin
            address      <= NBR_CNT_ADDR;
            i            <= '0;
            cur_best_q   <= '0;
            cur_best_id  <= NONE_ID;
            cur_best_idx <= '0;
            have_best    <= 1'b0;
            busy         <= 1'b1;
            state        <= S_RD_CNT;
          end
        end
        S_RD_CNT: begin
          cnt <= cnt_clamped_c;
          if (cnt_clamped_c == '0) begin
            state <= S_WR_BEST;
          end else begin
            address <= QVAL_BASE;
            state   <= S_RD_Q;
          end
        end
        S_RD_Q: begin
          q       <= data_in;
          address <= NBR_ID_BASE + ADDR_W'({i, 1'b0});
          state   <= S_RD_ID;
        end
        S_RD_ID: begin
          if (take_cand_c) begin
            cur_best_q   <= q;
            cur_best_id  <= data_in;
            cur_best_idx <= i;
            have_best    <= 1'b1;
          end
          i <= i_nxt_c;
          if (i_nxt_c == cnt) begin
            state <= S_WR_BEST;
          end else begin
            address <= QVAL_BASE + ADDR_W'({i_nxt_c, 1'b0});
            state   <= S_RD_Q;
          end
        end
        S_WR_BEST: begin
          address  <= BEST_ADDR;
          data_out <= cur_best_id;
          wr_en    <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          best_id    <= cur_best_id;
          best_q     <= cur_best_q;
          best_idx   <= cur_best_idx;
          none_found <= (cnt == '0);
          state      <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_find_my_best.sv
// Scoreboard bench for find_my_best: a driver loads a word-addressed memory
// model and starts scans. For each scan it queues the result computed from
// the memory contents. A monitor pops the queued result on every done and
// checks the outputs, the write-back and the addresses that were issued.
module tb_find_my_best;

  localparam int unsigned CNT_A  = 11'h274;
  localparam int unsigned ID_A   = 11'h072;
  localparam int unsigned Q_A    = 11'h052;
  localparam int unsigned BEST_A = 11'h276;

  logic        clock, rst, en, start;
  logic [15:0] data_in;
  logic [10:0] address;
  logic [15:0] data_out;
  logic        wr_en;
  logic [15:0] best_id, best_q;
  logic [4:0]  best_idx;
  logic        none_found, busy, done;

  logic [15:0] mem [0:1023];

  find_my_best dut (
    .clock(clock), .rst(rst), .en(en), .start(start), .data_in(data_in),
    .address(address), .data_out(data_out), .wr_en(wr_en),
    .best_id(best_id), .best_q(best_q), .best_idx(best_idx),
    .none_found(none_found), .busy(busy), .done(done)
  );

  assign data_in = mem[address[10:1]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] id;
    logic [15:0] q;
    logic [4:0]  idx;
    logic        none;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int cur_n = 0;
  int addr_bad = 0;
  int max_rd_addr = 0;
  int wr_cnt = 0;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Result derived from memory contents: first index holding the maximum Q
  function automatic exp_t ref_model();
    exp_t e;
    int n;
    n = (mem[CNT_A/2] > 16'd16) ? 16 : int'(mem[CNT_A/2]);
    e.id = 16'hFFFF;
    e.q = 16'h0;
    e.idx = 5'd0;
    e.none = (n == 0);
    for (int k = 0; k < n; k++) begin
      if (k == 0 || mem[Q_A/2 + k] > e.q) begin
        e.q = mem[Q_A/2 + k];
        e.id = mem[ID_A/2 + k];
        e.idx = 5'(k);
      end
    end
    e.lat = (n == 0) ? 3 : 2 * n + 3;
    e.start_cyc = 0;
    return e;
  endfunction

  function automatic bit addr_ok(input int a, input int n);
    if (a == CNT_A || a == BEST_A) return 1'b1;
    if (a % 2 != 0) return 1'b0;
    if (a >= Q_A && a < Q_A + 2 * n) return 1'b1;
    if (a >= ID_A && a < ID_A + 2 * n) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: address legality, write capture and done-time comparison
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rst !== 1'b0) continue;
      if (busy === 1'b1 && wr_en !== 1'b1) begin
        if (!addr_ok(int'(address), cur_n)) addr_bad++;
        if (int'(address) != CNT_A && int'(address) != BEST_A && int'(address) > max_rd_addr)
          max_rd_addr = int'(address);
      end
      if (wr_en === 1'b1) begin
        wr_cnt++;
        wr_addr = address;
        wr_data = data_out;
      end
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("best_id", 32'(best_id), 32'(e.id));
          chk("best_q", 32'(best_q), 32'(e.q));
          chk("best_idx", 32'(best_idx), 32'(e.idx));
          chk("none_found", 32'(none_found), 32'(e.none));
          chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
          chk("write_count", 32'(wr_cnt), 32'd1);
          chk("write_addr", 32'(wr_addr), 32'(BEST_A));
          chk("write_data", 32'(wr_data), 32'(e.id));
          chk("addr_range", 32'(addr_bad), 32'd0);
          chk("busy_after_done", 32'(busy), 32'd0);
        end
        wr_cnt = 0;
      end
    end
  end

  task automatic load_random(input int cnt, input int qmax);
    mem[CNT_A/2] = 16'(cnt);
    for (int k = 0; k < 16; k++) mem[Q_A/2 + k] = 16'($urandom_range(0, qmax));
    for (int k = 0; k < 20; k++) mem[ID_A/2 + k] = 16'($urandom);
  endtask

  task automatic run_scan(input bit abort, input bit extra_start);
    exp_t e;
    bit seen;
    int bad;
    e = ref_model();
    cur_n = (mem[CNT_A/2] > 16'd16) ? 16 : int'(mem[CNT_A/2]);
    addr_bad = 0;
    max_rd_addr = 0;
    @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    e.start_cyc = cyc;
    if (abort) begin
      @(posedge clock);
      #1;
      rst = 1'b1;
      @(posedge clock);
      #1;
      chk("abort_address", 32'(address), 32'd0);
      chk("abort_data_out", 32'(data_out), 32'd0);
      chk("abort_wr_en", 32'(wr_en), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_none_found", 32'(none_found), 32'd0);
      chk("abort_best_id", 32'(best_id), 32'hFFFF);
      chk("abort_best_q", 32'(best_q), 32'd0);
      chk("abort_best_idx", 32'(best_idx), 32'd0);
      rst = 1'b0;
      bad = 0;
      repeat (12) begin
        @(posedge clock);
        #1;
        if (wr_en !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("abort_quiet", 32'(bad), 32'd0);
      chk("abort_no_write", 32'(wr_cnt), 32'd0);
      return;
    end
    sbq.push_back(e);
    seen = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clock);
      #1;
      if (extra_start) start = (k == 2 || k == 4);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      void'(sbq.pop_back());
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 1024; k++) mem[k] = 16'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_none_found", 32'(none_found), 32'd0);
    chk("rst_best_id", 32'(best_id), 32'hFFFF);
    chk("rst_best_q", 32'(best_q), 32'd0);
    chk("rst_best_idx", 32'(best_idx), 32'd0);
    rst = 1'b0;
    en = 1'b1;

    // Three neighbours, clear maximum at index 1
    load_random(3, 65535);
    mem[Q_A/2 + 0] = 16'd10; mem[Q_A/2 + 1] = 16'd40; mem[Q_A/2 + 2] = 16'd25;
    mem[ID_A/2 + 0] = 16'd3; mem[ID_A/2 + 1] = 16'd7; mem[ID_A/2 + 2] = 16'd9;
    run_scan(1'b0, 1'b0);
    chk("basic_id_port", 32'(best_id), 32'd7);

    // No neighbours: no table reads
    load_random(0, 65535);
    run_scan(1'b0, 1'b0);
    chk("empty_no_reads", 32'(max_rd_addr), 32'd0);
    chk("empty_best_id", 32'(best_id), 32'hFFFF);

    // Tie keeps the lower index
    load_random(3, 65535);
    mem[Q_A/2 + 0] = 16'd50; mem[Q_A/2 + 1] = 16'd50; mem[Q_A/2 + 2] = 16'd20;
    mem[ID_A/2 + 0] = 16'd4; mem[ID_A/2 + 1] = 16'd5; mem[ID_A/2 + 2] = 16'd6;
    run_scan(1'b0, 1'b0);
    chk("tie_idx", 32'(best_idx), 32'd0);

    // Count above capacity is clamped; maximum in the last entry
    load_random(20, 400);
    mem[Q_A/2 + 15] = 16'd500;
    run_scan(1'b0, 1'b0);
    chk("clamp_max_addr", 32'(max_rd_addr), 32'h090);
    chk("clamp_idx", 32'(best_idx), 32'd15);

    // Reset during the first Q read of a four-neighbour scan
    load_random(4, 65535);
    run_scan(1'b1, 1'b0);
    load_random(4, 65535);
    run_scan(1'b0, 1'b0);

    // start with en low is ignored
    en = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    begin
      int bad;
      bad = 0;
      repeat (6) begin
        @(posedge clock);
        #1;
        if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) bad++;
      end
      chk("en_low_ignored", 32'(bad), 32'd0);
    end
    en = 1'b1;

    // start pulses while busy are ignored
    load_random(5, 65535);
    run_scan(1'b0, 1'b1);

    // Random scans: small Q range for frequent ties, occasional huge counts
    for (int r = 0; r < 40; r++) begin
      int c;
      c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 20));
      load_random(c, (r % 2 == 0) ? 7 : 65535);
      run_scan(1'b0, r % 5 == 0);
    end

    repeat (5) @(posedge clock);
    #1;
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
